// File: rtl/digit_serial_pkg.sv
// digit_serial_pkg: shared state encoding, slice width and digit-count helper
// for the digit-serial adder.
package digit_serial_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic int digit_count(input int width);
        return width / SLICE_W;
    endfunction

endpackage

// File: rtl/cla4_slice.sv
// cla4_slice: combinational 4-bit generate/propagate carry-lookahead adder slice.
module cla4_slice (
    input  logic [3:0] a4,
    input  logic [3:0] b4,
    input  logic       ci,
    output logic [3:0] s4,
    output logic       co
);

    logic [3:0] w_g, w_p, w_c;

    assign w_g = a4 & b4;
    assign w_p = a4 ^ b4;

    // All carries are flattened so none of them ripples through another.
    assign w_c[0] = ci;
    assign w_c[1] = w_g[0] | (w_p[0] & ci);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & ci);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & ci);
    assign co     = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & ci);

    assign s4 = w_p ^ w_c;

endmodule

// File: rtl/digit_serial_adder.sv
// digit_serial_adder: WIDTH-bit add/subtract computed one 4-bit digit per clock
// through a single lookahead slice, with valid/ready handshakes on both sides.
module digit_serial_adder
    import digit_serial_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = digit_count(WIDTH);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_t             r_state, w_next;
    logic [WIDTH-1:0]   r_a, r_b, r_sum;
    logic               r_c, r_cout, r_ovf;
    logic [CW-1:0]      r_k;
    logic [SLICE_W-1:0] w_a4, w_b4, w_s4;
    logic               w_co, w_last, w_accept;

    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_last   = (r_k == CW'(N - 1));
    assign w_a4     = r_a[r_k*SLICE_W +: SLICE_W];
    assign w_b4     = r_b[r_k*SLICE_W +: SLICE_W];

    cla4_slice u_slice (
        .a4 (w_a4),
        .b4 (w_b4),
        .ci (r_c),
        .s4 (w_s4),
        .co (w_co)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_next = w_accept                        ? RUN  :
                 (r_state == RUN  && w_last)     ? DONE :
                 (r_state == DONE && out_ready)  ? IDLE : r_state;
    end

    // Subtraction is a + ~b + 1, so the operand inversion and forced carry are
    // applied once at capture and the digit loop only ever adds.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_c    <= 1'b0;
            r_k    <= '0;
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_accept) begin
            r_a <= a;
            r_b <= sub ? ~b : b;
            r_c <= sub ? 1'b1 : cin;
            r_k <= '0;
        end else if (r_state == RUN) begin
            r_sum[r_k*SLICE_W +: SLICE_W] <= w_s4;
            r_c <= w_co;
            r_k <= w_last ? r_k : r_k + CW'(1);
            if (w_last) begin
                r_cout <= w_co;
                r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_s4[SLICE_W-1] != r_a[WIDTH-1]);
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_digit_serial_adder.sv
// tb_digit_serial_adder: directed and randomized checks of the 16-bit
// digit-serial adder against an integer-arithmetic reference model.
module tb_digit_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [15:0] a, b, sum;
    int          n_cmp = 0;
    int          n_fail = 0;

    digit_serial_adder #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Returns {ovf, cout, sum} from plain signed/unsigned integer arithmetic.
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic c, input logic s);
        logic [16:0] u;
        int          sr;
        logic        co, ov;
        if (s) begin
            u  = {1'b0, x} - {1'b0, y};
            co = (x >= y);
            sr = int'($signed(x)) - int'($signed(y));
        end else begin
            u  = {1'b0, x} + {1'b0, y} + {16'd0, c};
            co = u[16];
            sr = int'($signed(x)) + int'($signed(y)) + int'(c);
        end
        ov = (sr > 32767) || (sr < -32768);
        return {ov, co, u[15:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic c,
                          input logic s, input int hold, input logic [17:0] exp);
        int edges;
        @(negedge clk);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        a = x; b = y; cin = c; sub = s; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        check("in_ready_run", 32'(in_ready), 32'd0);
        edges = 0;
        while (!out_valid && edges < 20) begin
            @(negedge clk);
            edges++;
        end
        check("latency", 32'(edges), 32'd4);
        check("result", 32'({ovf, cout, sum}), 32'(exp));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom); a = 16'($urandom); b = 16'($urandom);
            @(negedge clk);
            check("held_result", 32'({ovf, cout, sum}), 32'(exp));
            check("in_ready_done", 32'(in_ready), 32'd0);
            check("out_valid_held", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_fall", 32'(out_valid), 32'd0);
        check("in_ready_rise", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [15:0] x, y;
        logic        c, s;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_outputs", 32'({ovf, cout, sum}), 32'd0);

        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0, {1'b0, 1'b0, 16'h5555});
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1, {1'b0, 1'b1, 16'h0000});
        run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 0, {1'b0, 1'b1, 16'h0000});
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 2, {1'b1, 1'b0, 16'h8000});
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0, {1'b1, 1'b1, 16'h7FFF});
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0, {1'b0, 1'b0, 16'hFFFE});
        run_op(16'hA5A5, 16'h1357, 1'b1, 1'b0, 5, model(16'hA5A5, 16'h1357, 1'b1, 1'b0));

        // Abort: reset lands on the edge after the second digit edge.
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_outputs", 32'({ovf, cout, sum}), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort_no_valid", 32'(out_valid), 32'd0);
        end
        run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 0, {1'b0, 1'b0, 16'h1000});

        for (int i = 0; i < 40; i++) begin
            x = 16'($urandom); y = 16'($urandom);
            c = 1'($urandom);  s = 1'($urandom);
            if (i % 8 == 0) y = 16'hFFFF - x;
            if (i % 8 == 1) y = x;
            run_op(x, y, c, s, int'($urandom_range(0, 3)), model(x, y, c, s));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
